// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM read/write port between an instruction-fetch (IF)
// requester and a load/store (LS) requester.
//
// Build option: MEM_ARB_RR_EN -- when defined, simultaneous requests in IDLE
// alternate between the two requesters (round-robin). When it is undefined,
// LS always wins.
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no access in flight; grants a request and latches its fields
// S_ISSUE | ram_rw_cen_o high for this single cycle
// S_WAIT  | waiting for ram_rw_ready_i, bounded by TIMEOUT cycles
//
// On a timeout, the owner's valid pulse comes from a registered flag in the
// first cycle back in IDLE. err_o is also high in that cycle. No new grant is
// made in that cycle, because the owner is still holding its request at the
// point where it sees its valid.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic [2:0]  if_size_i,
  output logic        if_valid_o,
  output logic [63:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_wen_i,
  input  logic [63:0] ls_addr_i,
  input  logic [63:0] ls_wdata_i,
  input  logic [7:0]  ls_wmask_i,
  input  logic [2:0]  ls_size_i,
  output logic        ls_valid_o,
  output logic [63:0] ls_data_o,
  output logic        ram_rw_cen_o,
  output logic        ram_rw_wen_o,
  output logic [63:0] ram_rw_addr_o,
  output logic [63:0] ram_rw_wdata_o,
  output logic [7:0]  ram_rw_wmask_o,
  output logic [2:0]  ram_rw_size_o,
  input  logic        ram_rw_ready_i,
  input  logic [63:0] ram_rw_data_i,
  output logic        err_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // owner encoding: 0 = IF, 1 = LS
  state_t          r_state;
  logic            r_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_err;
  logic            r_to_valid;
  logic            r_cen;
  logic            r_wen;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [7:0]      r_wmask;
  logic [2:0]      r_size;
`ifdef MEM_ARB_RR_EN
  logic            r_last_owner;
`endif

  logic            w_any_req;
  logic            w_grant_ls;
  logic            w_ram_done;
  logic            w_done;
  logic [63:0]     w_rdata;

  assign w_any_req = if_req_i | ls_req_i;

`ifdef MEM_ARB_RR_EN
  // On contention, grant whichever requester did not own the previous access.
  assign w_grant_ls = (if_req_i & ls_req_i) ? ~r_last_owner : ls_req_i;
`else
  assign w_grant_ls = ls_req_i;
`endif

  // Sequencer: grant and latch in IDLE, single-cycle issue, bounded wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_to_valid <= 1'b0;
      r_cen      <= 1'b0;
      r_wen      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_size     <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_owner <= 1'b0;
`endif
    end else begin
      r_to_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req && !r_to_valid) begin
            r_state <= S_ISSUE;
            r_owner <= w_grant_ls;
            r_cen   <= 1'b1;
`ifdef MEM_ARB_RR_EN
            r_last_owner <= w_grant_ls;
`endif
            if (w_grant_ls) begin
              r_wen   <= ls_wen_i;
              r_addr  <= ls_addr_i;
              r_wdata <= ls_wdata_i;
              r_wmask <= ls_wmask_i;
              r_size  <= ls_size_i;
            end else begin
              r_wen   <= 1'b0;
              r_addr  <= if_addr_i;
              r_wdata <= '0;
              r_wmask <= '0;
              r_size  <= if_size_i;
            end
          end
        end
        S_ISSUE: begin
          r_cen   <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (ram_rw_ready_i) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_to_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_ram_done = (r_state == S_WAIT) && ram_rw_ready_i;
  assign w_done     = w_ram_done | r_to_valid;
  assign w_rdata    = r_to_valid ? 64'd0 : ram_rw_data_i;

  assign if_valid_o = w_done & ~r_owner;
  assign ls_valid_o = w_done & r_owner;
  assign if_data_o  = w_rdata;
  assign ls_data_o  = w_rdata;

  assign ram_rw_cen_o   = r_cen;
  assign ram_rw_wen_o   = r_wen;
  assign ram_rw_addr_o  = r_addr;
  assign ram_rw_wdata_o = r_wdata;
  assign ram_rw_wmask_o = r_wmask;
  assign ram_rw_size_o  = r_size;
  assign err_o          = r_err;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16; maximum WAIT-state cycles allowed before a transaction is abandoned.
REQ-002 Port: clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: if_req_i  in  1  fetch read request; held high until if_valid_o.
REQ-005 Port: if_addr_i  in  64  fetch byte address.
REQ-006 Port: if_size_i  in  3  fetch access size.
REQ-007 Port: if_valid_o  out  1  one-cycle pulse; fetch data valid.
REQ-008 Port: if_data_o  out  64  fetch read data.
REQ-009 Port: ls_req_i  in  1  load/store request; held high until ls_valid_o.
REQ-010 Port: ls_wen_i  in  1  ls_wen_i=1 is a store; ls_wen_i=0 is a load.
REQ-011 Port: ls_addr_i / ls_wdata_i  in  64 / 64  load/store address and store data.
REQ-012 Port: ls_wmask_i / ls_size_i  in  8 / 3  byte write mask and access size.
REQ-013 Port: ls_valid_o  out  1  one-cycle pulse; load data valid, or store acknowledged.
REQ-014 Port: ls_data_o  out  64  load read data.
REQ-015 Port: ram_rw_cen_o / ram_rw_wen_o  out  1 / 1  RAM port chip enable and write enable.
REQ-016 Port: ram_rw_addr_o / ram_rw_wdata_o  out  64 / 64  RAM port address and write data.
REQ-017 Port: ram_rw_wmask_o / ram_rw_size_o  out  8 / 3  RAM port byte mask and size.
REQ-018 Port: ram_rw_ready_i / ram_rw_data_i  in  1 / 64  RAM response; ready_i rises one cycle after a cen cycle.
REQ-019 Port: err_o  out  1  sticky timeout flag.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE, WAIT.
REQ-021 IDLE SHALL move to ISSUE when any request is high, stay in IDLE otherwise, and latch owner, address, size, wen, wdata and wmask from the granted requester.
REQ-022 Later changes on requester inputs SHALL NOT affect a transaction once it is latched.
REQ-023 Fixed priority: when both requests are high in IDLE, LS SHALL win.
REQ-024 All ram_rw_* outputs SHALL be registered; ram_rw_cen_o=1 only in ISSUE, for exactly one cycle.
REQ-025 ram_rw_wen_o, wdata and wmask SHALL be 0 for IF transactions.
REQ-026 ISSUE SHALL always go to WAIT.
REQ-027 In WAIT with ram_rw_ready_i=1, the owner's valid_o SHALL pulse in that same cycle, and the FSM SHALL return to IDLE.
REQ-028 if_data_o and ls_data_o SHALL pass ram_rw_data_i through combinationally; their values are defined only while the matching valid_o=1.
REQ-029 Latency SHALL be: request seen in IDLE at cycle 0 -> cen at cycle 1 -> valid_o at cycle 2; peak throughput is one access per 3 cycles.
REQ-030 A request still high in the cycle after valid_o SHALL be treated as a new request.
REQ-031 The WAIT counter SHALL clear on entering WAIT; if it reaches TIMEOUT without ram_rw_ready_i, the block SHALL set err_o, pulse the owner's valid_o with data forced to 0, and return to IDLE.
REQ-032 err_o SHALL clear only on reset.
REQ-033 ram_rw_ready_i outside WAIT SHALL be ignored.
REQ-034 if_valid_o and ls_valid_o SHALL never be high in the same cycle.

Reset
REQ-035 On rst_n=0, immediately: state=IDLE; all ram_rw_* outputs, valid_o outputs, err_o and the counter =0; owner=IF; last_owner=IF.
REQ-036 A transaction in flight at reset SHALL be discarded with no valid_o pulse.

Configuration
REQ-037 When MEM_ARB_RR_EN is defined, contention in IDLE SHALL be resolved round-robin: grant goes to the requester that is not last_owner; last_owner updates on every grant, and its reset value of IF makes the first contention go to LS.
REQ-038 When MEM_ARB_RR_EN is undefined, fixed LS priority SHALL apply and last_owner SHALL be omitted.

Verification
REQ-039 IF read 0x80000000 alone -> cen=1 at cycle 1 with addr 0x80000000 and wen=0; ready at cycle 2 -> if_valid_o=1 at cycle 2, if_data_o = RAM word.
REQ-040 LS store 0x80000010, wdata 0x1122334455667788, mask 0x0F -> one cen cycle with wen=1 and mask 0x0F; ls_valid_o pulses at cycle 2.
REQ-041 IF and LS requests high together, held for 2 transactions -> fixed: LS then LS; with MEM_ARB_RR_EN: LS then IF.
REQ-042 ready_i held low, TIMEOUT=16 -> 16 WAIT cycles, then err_o=1 and owner valid_o=1 with data 0; FSM back in IDLE.
REQ-043 rst_n dropped in WAIT -> all outputs 0 at once; no valid_o after release; the next request completes normally.
REQ-044 ready_i pulsed while IDLE -> no valid_o; no state change.
